// File: rtl/shifter_sequencer.sv
// shifter_sequencer: fetches 16-bit pixel words into a one-entry buffer and sequences shifter load/shift strobes per line
// Ports: dotclk_i/reset_i clock and async active-high reset; hstart_i/bpp_i/words_i line start and config;
//   word_req_o/word_ack_i/word_dat_i word fetch handshake; dat_o/load_o/shift{1,2,4,8}_o shifter control;
//   active_o/line_done_o/underrun_o line status.
module shifter_sequencer #(
  parameter int WORDS_W = 8
) (
  input  logic               dotclk_i,
  input  logic               reset_i,
  input  logic               hstart_i,
  input  logic [1:0]         bpp_i,
  input  logic [WORDS_W-1:0] words_i,
  output logic               word_req_o,
  input  logic               word_ack_i,
  input  logic [15:0]        word_dat_i,
  output logic [15:0]        dat_o,
  output logic               load_o,
  output logic               shift1_o,
  output logic               shift2_o,
  output logic               shift4_o,
  output logic               shift8_o,
  output logic               active_o,
  output logic               line_done_o,
  output logic               underrun_o
);
  typedef enum logic [1:0] {IDLE, PRIME, ACTIVE, DRAIN} state_t;
  state_t             r_state, w_state_n;
  logic [1:0]         r_bpp;
  logic [WORDS_W-1:0] r_words, r_fetched, r_consumed, w_words_n, w_fetched_n, w_consumed_n;
  logic [15:0]        r_buf;
  logic               r_full, w_full_n, w_ack, w_start, w_eol, w_load_n, w_req_n;
  logic [3:0]         r_pix, w_pix_n, w_ppw_m1;

  assign dat_o = r_full ? r_buf : 16'h0000;

  always_comb begin
    w_ppw_m1 = 4'hF >> r_bpp;
    w_ack = word_req_o && word_ack_i;
    w_start = r_state == IDLE && hstart_i && words_i != '0;
    // last pixel of the last word: every word has already been loaded
    w_eol = r_state == ACTIVE && r_pix == w_ppw_m1 && r_consumed == r_words;
    w_state_n = r_state;
    case (r_state)
      IDLE:   w_state_n = w_start ? PRIME : IDLE;
      PRIME:  w_state_n = load_o ? ACTIVE : PRIME;
      ACTIVE: w_state_n = !w_eol ? ACTIVE : (word_req_o && !word_ack_i) ? DRAIN : IDLE;
      DRAIN:  w_state_n = w_ack ? IDLE : DRAIN;
    endcase
    w_words_n = w_start ? words_i : r_words;
    w_fetched_n = w_start ? '0 : r_fetched + WORDS_W'(w_ack);
    // every load cycle consumes a word, including an underrun with an empty buffer
    w_consumed_n = w_start ? '0 : r_consumed + WORDS_W'(load_o);
    // an ack only arrives with the buffer empty, so it never collides with a real load
    w_full_n = (w_state_n == IDLE || w_state_n == DRAIN) ? 1'b0 : w_ack ? 1'b1 : load_o ? 1'b0 : r_full;
    w_pix_n = (r_state == ACTIVE && r_pix != w_ppw_m1) ? r_pix + 4'd1 : 4'd0;
    w_load_n = (r_state == PRIME && w_ack) ||
               (r_state == ACTIVE && w_state_n == ACTIVE && w_pix_n == w_ppw_m1 && w_consumed_n < r_words);
    w_req_n = w_state_n == DRAIN ||
              ((w_state_n == PRIME || w_state_n == ACTIVE) && !w_full_n && w_fetched_n < w_words_n);
  end

  always_ff @(posedge dotclk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= IDLE;
      r_bpp       <= 2'd0;
      r_words     <= '0;
      r_fetched   <= '0;
      r_consumed  <= '0;
      r_buf       <= 16'h0000;
      r_full      <= 1'b0;
      r_pix       <= 4'd0;
      word_req_o  <= 1'b0;
      load_o      <= 1'b0;
      underrun_o  <= 1'b0;
      shift1_o    <= 1'b0;
      shift2_o    <= 1'b0;
      shift4_o    <= 1'b0;
      shift8_o    <= 1'b0;
      active_o    <= 1'b0;
      line_done_o <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_bpp       <= w_start ? bpp_i : r_bpp;
      r_words     <= w_words_n;
      r_fetched   <= w_fetched_n;
      r_consumed  <= w_consumed_n;
      r_buf       <= (w_ack && w_full_n) ? word_dat_i : r_buf;
      r_full      <= w_full_n;
      r_pix       <= w_pix_n;
      word_req_o  <= w_req_n;
      load_o      <= w_load_n;
      // load scheduled while no word will be buffered in time
      underrun_o  <= w_load_n && !w_full_n;
      shift1_o    <= w_state_n == ACTIVE && r_bpp == 2'd0;
      shift2_o    <= w_state_n == ACTIVE && r_bpp == 2'd1;
      shift4_o    <= w_state_n == ACTIVE && r_bpp == 2'd2;
      shift8_o    <= w_state_n == ACTIVE && r_bpp == 2'd3;
      active_o    <= w_state_n == ACTIVE;
      line_done_o <= w_eol;
    end
  end
endmodule

// File: tb/tb_shifter_sequencer.sv
// tb_shifter_sequencer: table, hand-written and random line checks of shifter_sequencer against a line-level model
module tb_shifter_sequencer;
  logic        dotclk_i = 1'b0;
  logic        reset_i, hstart_i, word_ack_i;
  logic [1:0]  bpp_i;
  logic [7:0]  words_i;
  logic [15:0] word_dat_i, dat_o;
  logic        word_req_o, load_o, shift1_o, shift2_o, shift4_o, shift8_o, active_o, line_done_o, underrun_o;
  logic [24:0] outs;

  always #5 dotclk_i = ~dotclk_i;

  shifter_sequencer #(.WORDS_W(8)) dut (
    .dotclk_i(dotclk_i), .reset_i(reset_i), .hstart_i(hstart_i), .bpp_i(bpp_i), .words_i(words_i),
    .word_req_o(word_req_o), .word_ack_i(word_ack_i), .word_dat_i(word_dat_i), .dat_o(dat_o),
    .load_o(load_o), .shift1_o(shift1_o), .shift2_o(shift2_o), .shift4_o(shift4_o), .shift8_o(shift8_o),
    .active_o(active_o), .line_done_o(line_done_o), .underrun_o(underrun_o)
  );

  assign outs = {word_req_o, load_o, shift1_o, shift2_o, shift4_o, shift8_o, active_o, line_done_o, underrun_o, dat_o};

  typedef struct {
    logic [1:0]  bpp;
    int          words;
    logic [15:0] d0, d1;
    int          shifts, loads;
    logic [3:0]  strobe;
  } vec_t;

  int checks = 0, failures = 0, cyc = 0;
  logic [15:0] datas [16];
  logic [15:0] exp_dat [16];
  int delays [16];
  int exp_und, exp_rise;
  bit exp_drain;
  logic [3:0] exp_strobe, mon_s, seen_or;
  bit mon_en = 0, prev_req;
  int n_shift, n_load, n_und, n_done, n_rise, n_req_post, bad_strobe, bad_act;
  int first_shift_cyc, last_shift_cyc, done_cyc, load0_cyc, ack_cyc;
  logic [15:0] ld_dat [16];
  int ld_pos [16];
  int ri = 0, wcnt = 0;

  always @(posedge dotclk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // line observer: tallies strobes, loads and status pulses seen away from the clock edge
  initial forever begin
    @(negedge dotclk_i);
    if (mon_en) begin
      mon_s = {shift8_o, shift4_o, shift2_o, shift1_o};
      seen_or = seen_or | mon_s;
      if (mon_s != 4'b0) begin
        if (mon_s != exp_strobe) bad_strobe++;
        if (n_shift == 0) first_shift_cyc = cyc;
        last_shift_cyc = cyc;
      end
      if (active_o != (mon_s != 4'b0)) bad_act++;
      if (underrun_o && !load_o) bad_act++;
      if (load_o) begin
        if (n_load < 16) begin
          ld_dat[n_load] = dat_o;
          ld_pos[n_load] = n_shift;
        end
        if (n_load == 0) load0_cyc = cyc;
        n_load++;
      end
      if (mon_s != 4'b0) n_shift++;
      if (underrun_o) n_und++;
      if (word_req_o && !prev_req) n_rise++;
      prev_req = word_req_o;
      if (word_req_o && n_done > 0) n_req_post++;
      if (line_done_o) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  // memory side: acks request ri after delays[ri] cycles of word_req_o, and toggles ack noise while idle
  initial begin
    word_ack_i = 1'b0;
    word_dat_i = 16'h0;
    forever begin
      @(negedge dotclk_i);
      if (word_req_o && ri < 16 && wcnt >= delays[ri]) begin
        word_ack_i = 1'b1;
        word_dat_i = datas[ri];
        if (ri == 0) ack_cyc = cyc;
        ri++;
        wcnt = 0;
      end else begin
        if (word_req_o) wcnt++;
        word_ack_i = !word_req_o && ($urandom % 3 == 0);
        word_dat_i = 16'($urandom);
      end
    end
  end

  function automatic int ppw_of(input logic [1:0] bpp);
    return 16 / (1 << bpp);
  endfunction

  // model for a line whose words all arrive before they are needed
  task automatic plan_fast(input logic [1:0] bpp, input int words, input bit rand_delay);
    for (int k = 0; k < 16; k++) begin
      datas[k] = 16'($urandom);
      delays[k] = rand_delay ? $urandom_range(ppw_of(bpp) - 2, 0) : 0;
      exp_dat[k] = datas[k];
    end
    exp_und = 0;
    exp_rise = words;
    exp_drain = 0;
  endtask

  task automatic run_line(input logic [1:0] bpp, input int words, input bit noise);
    int ppw, total;
    ppw = ppw_of(bpp);
    total = words * ppw;
    exp_strobe = 4'(1 << bpp);
    n_shift = 0; n_load = 0; n_und = 0; n_done = 0; n_rise = 0; n_req_post = 0;
    bad_strobe = 0; bad_act = 0; seen_or = 4'b0; prev_req = 0;
    first_shift_cyc = -1; last_shift_cyc = -1; done_cyc = -1; load0_cyc = -1; ack_cyc = -1;
    ri = 0; wcnt = 0; mon_en = 1;
    @(negedge dotclk_i);
    bpp_i = bpp; words_i = 8'(words); hstart_i = 1'b1;
    @(negedge dotclk_i);
    hstart_i = 1'b0; bpp_i = 2'($urandom); words_i = 8'($urandom);
    for (int c = 0; c < (words == 0 ? 40 : 300) && n_done == 0; c++) begin
      @(negedge dotclk_i);
      hstart_i = noise && active_o && (n_shift + 4 < total) && ($urandom % 3 == 0);
      if (hstart_i) bpp_i = 2'b00;
    end
    hstart_i = 1'b0;
    for (int c = 0; c < 80 && word_req_o; c++) @(negedge dotclk_i);
    repeat (3) @(negedge dotclk_i);
    mon_en = 0;
    chk("done_count", n_done, words != 0);
    chk("shift_count", n_shift, total);
    chk("load_count", n_load, words);
    chk("underrun_count", n_und, exp_und);
    chk("req_rises", n_rise, exp_rise);
    chk("post_done_req", n_req_post != 0, exp_drain);
    chk("strobe_errors", bad_strobe, 0);
    chk("active_errors", bad_act, 0);
    chk("req_end", word_req_o, 0);
    if (words != 0) begin
      chk("done_time", done_cyc, last_shift_cyc + 1);
      chk("load_latency", load0_cyc, ack_cyc + 1);
      chk("shift_latency", first_shift_cyc, ack_cyc + 2);
      for (int k = 0; k < words && k < 16; k++) begin
        chk($sformatf("load_data[%0d]", k), ld_dat[k], exp_dat[k]);
        chk($sformatf("load_pos[%0d]", k), ld_pos[k], k == 0 ? 0 : k * ppw - 1);
      end
    end
  endtask

  vec_t vecs [5];

  initial begin
    vecs = '{
      '{bpp: 2'd3, words: 2, d0: 16'hA5C3, d1: 16'h1234, shifts: 4,  loads: 2, strobe: 4'b1000},
      '{bpp: 2'd0, words: 1, d0: 16'h8001, d1: 16'h0000, shifts: 16, loads: 1, strobe: 4'b0001},
      '{bpp: 2'd1, words: 3, d0: 16'hF00F, d1: 16'h0FF0, shifts: 24, loads: 3, strobe: 4'b0010},
      '{bpp: 2'd2, words: 2, d0: 16'h1357, d1: 16'h2468, shifts: 8,  loads: 2, strobe: 4'b0100},
      '{bpp: 2'd0, words: 0, d0: 16'h0000, d1: 16'h0000, shifts: 0,  loads: 0, strobe: 4'b0000}
    };
    for (int k = 0; k < 16; k++) delays[k] = 0;
    reset_i = 1'b1; hstart_i = 1'b0; bpp_i = 2'b0; words_i = 8'd0;
    #3;
    chk("reset_outputs", outs, 0);
    @(negedge dotclk_i);
    reset_i = 1'b0;

    foreach (vecs[i]) begin
      plan_fast(vecs[i].bpp, vecs[i].words, 0);
      datas[0] = vecs[i].d0; datas[1] = vecs[i].d1; datas[2] = vecs[i].d0 ^ vecs[i].d1;
      for (int k = 0; k < 3; k++) exp_dat[k] = datas[k];
      run_line(vecs[i].bpp, vecs[i].words, 0);
      chk("vec_shifts", n_shift, vecs[i].shifts);
      chk("vec_loads", n_load, vecs[i].loads);
      chk("vec_strobe", seen_or, vecs[i].strobe);
    end

    // second word withheld: two underrun loads, then the line drains the late ack
    plan_fast(2'd2, 3, 0);
    delays[1] = 30;
    exp_dat[1] = 16'h0; exp_dat[2] = 16'h0;
    exp_und = 2; exp_rise = 2; exp_drain = 1;
    run_line(2'd2, 3, 0);

    // hstart with 1bpp pulsed during an 8bpp line
    plan_fast(2'd3, 5, 0);
    run_line(2'd3, 5, 1);

    // asynchronous reset in the middle of an active line
    plan_fast(2'd0, 4, 0);
    ri = 0; wcnt = 0;
    @(negedge dotclk_i);
    bpp_i = 2'd0; words_i = 8'd4; hstart_i = 1'b1;
    @(negedge dotclk_i);
    hstart_i = 1'b0;
    for (int c = 0; c < 20 && !active_o; c++) @(negedge dotclk_i);
    repeat (3) @(negedge dotclk_i);
    chk("pre_reset_active", active_o, 1);
    #2 reset_i = 1'b1;
    #1 chk("mid_line_reset_outputs", outs, 0);
    @(negedge dotclk_i);
    reset_i = 1'b0;
    plan_fast(2'd1, 2, 1);
    run_line(2'd1, 2, 0);

    for (int n = 0; n < 16; n++) begin
      logic [1:0] b;
      int w;
      b = 2'($urandom);
      w = 1 + $urandom % 6;
      plan_fast(b, w, 1);
      run_line(b, w, $urandom % 2 == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
